// File: rtl/d20_pkg.sv
// Shared d20 definitions: die bounds, default result width and the history entry layout.
package d20_pkg;

  localparam int D20_MIN      = 1;
  localparam int D20_MAX      = 20;
  localparam int D20_NUM_BITS = 8;

  typedef struct packed {
    logic                           crit;
    logic                           fumble;
    logic                           hit;
    logic signed [D20_NUM_BITS-1:0] value;
  } roll_entry_t;

  function automatic logic is_legal(input logic [4:0] r);
    return (r >= 5'(D20_MIN)) && (r <= 5'(D20_MAX));
  endfunction

endpackage

// File: rtl/roll_hist_fifo.sv
// Show-ahead circular history buffer; a push into a full buffer drops the oldest entry.
module roll_hist_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic          valid,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          ovf
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full_s, empty_s, pop_s;

  assign full_s  = (cnt_q == LW'(DEPTH));
  assign empty_s = (cnt_q == LW'(0));
  assign pop_s   = pop & ~empty_s;

  // Pointer/occupancy update; a full push advances the read side to drop or hand over the head.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) begin
      wr_d = wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s || (push && full_s)) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    if (push && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    if (push && !full_s && !pop_s) begin
      cnt_d = cnt_q + LW'(1);
    end else if (pop_s && !push) begin
      cnt_d = cnt_q - LW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= AW'(0);
      rd_q  <= AW'(0);
      cnt_q <= LW'(0);
      ovf_q <= 1'b0;
    end else if (clear) begin
      wr_q  <= AW'(0);
      rd_q  <= AW'(0);
      cnt_q <= LW'(0);
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage is not reset; the output mux hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= din;
    end
  end

  assign valid = ~empty_s;
  assign dout  = empty_s ? W'(0) : mem_q[rd_q];
  assign level = cnt_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/roll_tally.sv
// Statistics stage after the d20 resolver: saturating tallies, hit streaks and a roll history.
module roll_tally import d20_pkg::*; #(
  parameter int NUM_BITS   = D20_NUM_BITS,
  parameter int CNT_BITS   = 16,
  parameter int SUM_BITS   = 16,
  parameter int HIST_DEPTH = 8,
  localparam int LW        = $clog2(HIST_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       roll_valid,
  input  logic [4:0]                 random_num,
  input  logic signed [NUM_BITS-1:0] final_num,
  input  logic                       hit,
  output logic [CNT_BITS-1:0]        roll_count,
  output logic [CNT_BITS-1:0]        hit_count,
  output logic [CNT_BITS-1:0]        crit_count,
  output logic [CNT_BITS-1:0]        fumble_count,
  output logic [CNT_BITS-1:0]        err_count,
  output logic signed [SUM_BITS-1:0] sum,
  output logic [CNT_BITS-1:0]        streak,
  output logic [CNT_BITS-1:0]        max_streak,
  output logic                       hist_valid,
  output logic [NUM_BITS+2:0]        hist_data,
  input  logic                       hist_rd,
  output logic [LW-1:0]              hist_level,
  output logic                       hist_ovf
);

  logic [CNT_BITS-1:0] roll_q, roll_d, hit_q, hit_d, crit_q, crit_d;
  logic [CNT_BITS-1:0] fum_q, fum_d, err_q, err_d, streak_q, streak_d, max_q, max_d;
  logic [SUM_BITS-1:0] sum_q, sum_d;
  logic [SUM_BITS:0]   sum_wide_s;
  logic                take_s, legal_s, acc_s, bad_s, crit_s, fum_s;
  logic [NUM_BITS+2:0] entry_s;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  assign take_s  = roll_valid & ~clear;
  assign legal_s = is_legal(random_num);
  assign acc_s   = take_s & legal_s;
  assign bad_s   = take_s & ~legal_s;
  assign crit_s  = (random_num == 5'(D20_MAX));
  assign fum_s   = (random_num == 5'(D20_MIN));
  assign entry_s = {crit_s, fum_s, hit, final_num};

  // One guard bit above the sum exposes signed overflow in either direction.
  assign sum_wide_s = {sum_q[SUM_BITS-1], sum_q}
                    + {{(SUM_BITS+1-NUM_BITS){final_num[NUM_BITS-1]}}, final_num};

  // Next-state for tallies, sum and streak.
  always_comb begin
    roll_d   = acc_s ? sat_inc(roll_q) : roll_q;
    hit_d    = (acc_s && hit) ? sat_inc(hit_q) : hit_q;
    crit_d   = (acc_s && crit_s) ? sat_inc(crit_q) : crit_q;
    fum_d    = (acc_s && fum_s) ? sat_inc(fum_q) : fum_q;
    err_d    = bad_s ? sat_inc(err_q) : err_q;
    sum_d    = sum_q;
    streak_d = streak_q;
    max_d    = max_q;
    if (!acc_s) begin
      sum_d = sum_q;
    end else if (sum_wide_s[SUM_BITS] ^ sum_wide_s[SUM_BITS-1]) begin
      sum_d = sum_wide_s[SUM_BITS] ? {1'b1, {(SUM_BITS-1){1'b0}}} : {1'b0, {(SUM_BITS-1){1'b1}}};
    end else begin
      sum_d = sum_wide_s[SUM_BITS-1:0];
    end
    if (acc_s && hit) begin
      streak_d = sat_inc(streak_q);
      max_d    = (streak_d > max_q) ? streak_d : max_q;
    end else if (acc_s) begin
      streak_d = CNT_BITS'(0);
      max_d    = max_q;
    end else begin
      streak_d = streak_q;
      max_d    = max_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      roll_q <= CNT_BITS'(0); hit_q <= CNT_BITS'(0); crit_q <= CNT_BITS'(0);
      fum_q <= CNT_BITS'(0); err_q <= CNT_BITS'(0); streak_q <= CNT_BITS'(0);
      max_q <= CNT_BITS'(0); sum_q <= SUM_BITS'(0);
    end else if (clear) begin
      roll_q <= CNT_BITS'(0); hit_q <= CNT_BITS'(0); crit_q <= CNT_BITS'(0);
      fum_q <= CNT_BITS'(0); err_q <= CNT_BITS'(0); streak_q <= CNT_BITS'(0);
      max_q <= CNT_BITS'(0); sum_q <= SUM_BITS'(0);
    end else begin
      roll_q <= roll_d; hit_q <= hit_d; crit_q <= crit_d;
      fum_q <= fum_d; err_q <= err_d; streak_q <= streak_d;
      max_q <= max_d; sum_q <= sum_d;
    end
  end

  roll_hist_fifo #(
    .W     (NUM_BITS + 3),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (acc_s),
    .din   (entry_s),
    .pop   (hist_rd),
    .valid (hist_valid),
    .dout  (hist_data),
    .level (hist_level),
    .ovf   (hist_ovf)
  );

  assign roll_count   = roll_q;
  assign hit_count    = hit_q;
  assign crit_count   = crit_q;
  assign fumble_count = fum_q;
  assign err_count    = err_q;
  assign sum          = sum_q;
  assign streak       = streak_q;
  assign max_streak   = max_q;

endmodule

// File: tb/tb_roll_tally.sv
// Self-checking bench for roll_tally: directed scenarios plus a randomized run against a queue model.
module tb_roll_tally;
  import d20_pkg::*;

  logic clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic roll_valid = 1'b0, hit = 1'b0, hist_rd = 1'b0;
  logic [4:0] random_num = 5'd0;
  logic signed [7:0] final_num = 8'sd0;
  logic [15:0] roll_count, hit_count, crit_count, fumble_count, err_count, streak, max_streak;
  logic signed [15:0] sum;
  logic hist_valid, hist_ovf;
  logic [10:0] hist_data;
  logic [3:0] hist_level;

  logic roll_valid2 = 1'b0, hit2 = 1'b0, hist_rd2 = 1'b0;
  logic [4:0] random_num2 = 5'd0;
  logic signed [7:0] final_num2 = 8'sd0;
  logic [3:0] roll_count2, hit_count2, crit_count2, fumble_count2, err_count2, streak2, max_streak2;
  logic signed [7:0] sum2;
  logic hist_valid2, hist_ovf2;
  logic [10:0] hist_data2;
  logic [2:0] hist_level2;

  int n_pass = 0, n_tot = 0;

  int m_roll, m_hit, m_crit, m_fum, m_err, m_sum, m_streak, m_max;
  bit m_ovf;
  logic [10:0] m_q[$];

  always #5 clk = ~clk;

  roll_tally dut (
    .clk(clk), .reset(reset), .clear(clear), .roll_valid(roll_valid),
    .random_num(random_num), .final_num(final_num), .hit(hit),
    .roll_count(roll_count), .hit_count(hit_count), .crit_count(crit_count),
    .fumble_count(fumble_count), .err_count(err_count), .sum(sum),
    .streak(streak), .max_streak(max_streak), .hist_valid(hist_valid),
    .hist_data(hist_data), .hist_rd(hist_rd), .hist_level(hist_level), .hist_ovf(hist_ovf)
  );

  roll_tally #(.NUM_BITS(8), .CNT_BITS(4), .SUM_BITS(8), .HIST_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .roll_valid(roll_valid2),
    .random_num(random_num2), .final_num(final_num2), .hit(hit2),
    .roll_count(roll_count2), .hit_count(hit_count2), .crit_count(crit_count2),
    .fumble_count(fumble_count2), .err_count(err_count2), .sum(sum2),
    .streak(streak2), .max_streak(max_streak2), .hist_valid(hist_valid2),
    .hist_data(hist_data2), .hist_rd(hist_rd2), .hist_level(hist_level2), .hist_ovf(hist_ovf2)
  );

  function automatic int cinc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    m_roll = 0; m_hit = 0; m_crit = 0; m_fum = 0; m_err = 0;
    m_sum = 0; m_streak = 0; m_max = 0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [4:0] r, input int f, input logic h, input logic rd);
    logic [7:0] fb;
    fb = 8'(f);
    if (clear) begin
      model_reset();
    end else begin
      if (rd && m_q.size() > 0) void'(m_q.pop_front());
      if (v) begin
        if (r >= 5'd1 && r <= 5'd20) begin
          m_roll = cinc(m_roll);
          if (h) m_hit = cinc(m_hit);
          if (r == 5'd20) m_crit = cinc(m_crit);
          if (r == 5'd1) m_fum = cinc(m_fum);
          m_sum = m_sum + f;
          if (m_sum > 32767) m_sum = 32767;
          if (m_sum < -32768) m_sum = -32768;
          if (h) begin
            m_streak = cinc(m_streak);
            if (m_streak > m_max) m_max = m_streak;
          end else begin
            m_streak = 0;
          end
          m_q.push_back({r == 5'd20, r == 5'd1, h, fb});
          if (m_q.size() > 8) begin
            void'(m_q.pop_front());
            m_ovf = 1'b1;
          end
        end else begin
          m_err = cinc(m_err);
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input int f, input logic h, input logic rd);
    roll_valid = v; random_num = r; final_num = 8'(f); hit = h; hist_rd = rd;
    model_step(v, r, f, h, rd);
    @(posedge clk); #1;
    roll_valid = 1'b0; hist_rd = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    model_reset();
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_tot++; if (roll_count !== 16'd0) $display("FAIL reset roll_count got %0d exp 0", roll_count); else n_pass++;
    n_tot++; if (err_count !== 16'd0) $display("FAIL reset err_count got %0d exp 0", err_count); else n_pass++;
    n_tot++; if (sum !== 16'sd0) $display("FAIL reset sum got %0d exp 0", sum); else n_pass++;
    n_tot++; if (max_streak !== 16'd0) $display("FAIL reset max_streak got %0d exp 0", max_streak); else n_pass++;
    n_tot++; if ({hist_valid, hist_ovf, hist_level} !== 6'd0) $display("FAIL reset hist_flags got %b exp 0", {hist_valid, hist_ovf, hist_level}); else n_pass++;
    n_tot++; if (hist_data !== 11'd0) $display("FAIL reset hist_data got %h exp 0", hist_data); else n_pass++;
  endtask

  task automatic test_basic();
    roll_entry_t e;
    e = '{crit: 1'b1, fumble: 1'b0, hit: 1'b1, value: 8'sd25};
    drive(1'b1, 5'd20, 25, 1'b1, 1'b0);
    n_tot++; if (hist_valid !== 1'b1) $display("FAIL basic hist_valid_after_push got %b exp 1", hist_valid); else n_pass++;
    drive(1'b1, 5'd1, -2, 1'b0, 1'b0);
    drive(1'b1, 5'd12, 12, 1'b1, 1'b0);
    n_tot++; if (roll_count !== 16'd3) $display("FAIL basic roll_count got %0d exp 3", roll_count); else n_pass++;
    n_tot++; if (hit_count !== 16'd2) $display("FAIL basic hit_count got %0d exp 2", hit_count); else n_pass++;
    n_tot++; if (crit_count !== 16'd1) $display("FAIL basic crit_count got %0d exp 1", crit_count); else n_pass++;
    n_tot++; if (fumble_count !== 16'd1) $display("FAIL basic fumble_count got %0d exp 1", fumble_count); else n_pass++;
    n_tot++; if (sum !== 16'sd35) $display("FAIL basic sum got %0d exp 35", sum); else n_pass++;
    n_tot++; if (streak !== 16'd1 || max_streak !== 16'd1) $display("FAIL basic streak got %0d/%0d exp 1/1", streak, max_streak); else n_pass++;
    n_tot++; if (hist_level !== 4'd3) $display("FAIL basic hist_level got %0d exp 3", hist_level); else n_pass++;
    n_tot++; if (hist_data !== 11'(e)) $display("FAIL basic hist_head got %h exp %h", hist_data, 11'(e)); else n_pass++;
  endtask

  task automatic test_illegal();
    drive(1'b1, 5'd0, 50, 1'b1, 1'b0);
    drive(1'b1, 5'd21, 50, 1'b0, 1'b0);
    n_tot++; if (err_count !== 16'd2) $display("FAIL illegal err_count got %0d exp 2", err_count); else n_pass++;
    n_tot++; if (roll_count !== 16'd3 || hit_count !== 16'd2) $display("FAIL illegal tallies got %0d/%0d exp 3/2", roll_count, hit_count); else n_pass++;
    n_tot++; if (sum !== 16'sd35 || streak !== 16'd1) $display("FAIL illegal sum_streak got %0d/%0d exp 35/1", sum, streak); else n_pass++;
    n_tot++; if (hist_level !== 4'd3) $display("FAIL illegal hist_level got %0d exp 3", hist_level); else n_pass++;
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 1; i <= 10; i++) drive(1'b1, 5'd10, i, 1'b0, 1'b0);
    n_tot++; if (hist_level !== 4'd8) $display("FAIL ovf hist_level got %0d exp 8", hist_level); else n_pass++;
    n_tot++; if (hist_ovf !== 1'b1) $display("FAIL ovf hist_ovf got %b exp 1", hist_ovf); else n_pass++;
    for (int i = 3; i <= 10; i++) begin
      n_tot++; if (hist_valid !== 1'b1 || hist_data[7:0] !== 8'(i)) $display("FAIL ovf drain got v=%b %0d exp %0d", hist_valid, hist_data[7:0], i); else n_pass++;
      drive(1'b0, 5'd0, 0, 1'b0, 1'b1);
    end
    n_tot++; if (hist_valid !== 1'b0 || hist_level !== 4'd0) $display("FAIL ovf empty got v=%b l=%0d exp 0/0", hist_valid, hist_level); else n_pass++;
    drive(1'b0, 5'd0, 0, 1'b0, 1'b1);
    n_tot++; if (hist_level !== 4'd0 || hist_data !== 11'd0) $display("FAIL ovf underflow got l=%0d d=%h exp 0/0", hist_level, hist_data); else n_pass++;
    n_tot++; if (hist_ovf !== 1'b1) $display("FAIL ovf sticky got %b exp 1", hist_ovf); else n_pass++;
    drive(1'b1, 5'd5, 77, 1'b0, 1'b1);
    n_tot++; if (hist_level !== 4'd1 || hist_data[7:0] !== 8'd77) $display("FAIL ovf empty_pushpop got l=%0d d=%0d exp 1/77", hist_level, hist_data[7:0]); else n_pass++;
  endtask

  task automatic test_full_pushpop();
    do_clear();
    for (int i = 11; i <= 18; i++) drive(1'b1, 5'd10, i, 1'b0, 1'b0);
    n_tot++; if (hist_data[7:0] !== 8'd11) $display("FAIL fullpp old_head got %0d exp 11", hist_data[7:0]); else n_pass++;
    drive(1'b1, 5'd10, 19, 1'b0, 1'b1);
    n_tot++; if (hist_level !== 4'd8 || hist_ovf !== 1'b0) $display("FAIL fullpp level_ovf got %0d/%b exp 8/0", hist_level, hist_ovf); else n_pass++;
    for (int i = 12; i <= 19; i++) begin
      n_tot++; if (hist_data[7:0] !== 8'(i)) $display("FAIL fullpp drain got %0d exp %0d", hist_data[7:0], i); else n_pass++;
      drive(1'b0, 5'd0, 0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_random();
    logic v, h, rd;
    logic [4:0] r;
    int f;
    logic [10:0] exp_d;
    do_clear();
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 3) != 0);
      r = 5'($urandom_range(0, 22));
      f = $urandom_range(0, 255) - 128;
      h = ($urandom_range(0, 4) < 3);
      rd = ($urandom_range(0, 2) == 0);
      drive(v, r, f, h, rd);
      exp_d = (m_q.size() > 0) ? m_q[0] : 11'd0;
      n_tot++; if (roll_count !== 16'(m_roll)) $display("FAIL rand roll_count got %0d exp %0d", roll_count, m_roll); else n_pass++;
      n_tot++; if (hit_count !== 16'(m_hit)) $display("FAIL rand hit_count got %0d exp %0d", hit_count, m_hit); else n_pass++;
      n_tot++; if (crit_count !== 16'(m_crit)) $display("FAIL rand crit_count got %0d exp %0d", crit_count, m_crit); else n_pass++;
      n_tot++; if (fumble_count !== 16'(m_fum)) $display("FAIL rand fumble_count got %0d exp %0d", fumble_count, m_fum); else n_pass++;
      n_tot++; if (err_count !== 16'(m_err)) $display("FAIL rand err_count got %0d exp %0d", err_count, m_err); else n_pass++;
      n_tot++; if (sum !== 16'(m_sum)) $display("FAIL rand sum got %0d exp %0d", sum, m_sum); else n_pass++;
      n_tot++; if (streak !== 16'(m_streak) || max_streak !== 16'(m_max)) $display("FAIL rand streak got %0d/%0d exp %0d/%0d", streak, max_streak, m_streak, m_max); else n_pass++;
      n_tot++; if (hist_level !== 4'(m_q.size()) || hist_valid !== (m_q.size() > 0)) $display("FAIL rand hist_level got %0d exp %0d", hist_level, m_q.size()); else n_pass++;
      n_tot++; if (hist_ovf !== m_ovf) $display("FAIL rand hist_ovf got %b exp %b", hist_ovf, m_ovf); else n_pass++;
      n_tot++; if (hist_data !== exp_d) $display("FAIL rand hist_data got %h exp %h", hist_data, exp_d); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    roll_valid2 = 1'b1; random_num2 = 5'd20; final_num2 = 8'sd127; hit2 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_tot++; if (sum2 !== 8'sd127) $display("FAIL sat sum_pos got %0d exp 127", sum2); else n_pass++;
    n_tot++; if (roll_count2 !== 4'hF || crit_count2 !== 4'hF) $display("FAIL sat counters got %0d/%0d exp 15/15", roll_count2, crit_count2); else n_pass++;
    n_tot++; if (streak2 !== 4'hF || max_streak2 !== 4'hF) $display("FAIL sat streak got %0d/%0d exp 15/15", streak2, max_streak2); else n_pass++;
    n_tot++; if (hist_level2 !== 3'd4 || hist_ovf2 !== 1'b1) $display("FAIL sat hist got %0d/%b exp 4/1", hist_level2, hist_ovf2); else n_pass++;
    random_num2 = 5'd5; final_num2 = -8'sd128; hit2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    roll_valid2 = 1'b0;
    n_tot++; if (sum2 !== -8'sd128) $display("FAIL sat sum_neg got %0d exp -128", sum2); else n_pass++;
    n_tot++; if (streak2 !== 4'd0 || max_streak2 !== 4'hF) $display("FAIL sat streak_reset got %0d/%0d exp 0/15", streak2, max_streak2); else n_pass++;
  endtask

  task automatic test_clear_with_roll();
    drive(1'b1, 5'd20, 30, 1'b1, 1'b0);
    drive(1'b1, 5'd7, 9, 1'b1, 1'b0);
    clear = 1'b1;
    drive(1'b1, 5'd20, 25, 1'b1, 1'b0);
    clear = 1'b0;
    n_tot++; if (roll_count !== 16'd0 || hit_count !== 16'd0 || crit_count !== 16'd0) $display("FAIL clear tallies got %0d/%0d/%0d exp 0", roll_count, hit_count, crit_count); else n_pass++;
    n_tot++; if (sum !== 16'sd0 || streak !== 16'd0 || max_streak !== 16'd0) $display("FAIL clear sum_streak got %0d/%0d/%0d exp 0", sum, streak, max_streak); else n_pass++;
    n_tot++; if (hist_valid !== 1'b0 || hist_level !== 4'd0 || hist_data !== 11'd0) $display("FAIL clear hist got %b/%0d/%h exp 0", hist_valid, hist_level, hist_data); else n_pass++;
    n_tot++; if (sum2 !== 8'sd0 || roll_count2 !== 4'd0) $display("FAIL clear dut2 got %0d/%0d exp 0/0", sum2, roll_count2); else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd20, 40, 1'b1, 1'b0);
    drive(1'b1, 5'd0, 1, 1'b0, 1'b0);
    roll_valid = 1'b1; random_num = 5'd15; final_num = 8'sd3; hit = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_tot++; if (roll_count !== 16'd0 || err_count !== 16'd0 || sum !== 16'sd0) $display("FAIL areset tallies got %0d/%0d/%0d exp 0", roll_count, err_count, sum); else n_pass++;
    n_tot++; if (streak !== 16'd0 || max_streak !== 16'd0) $display("FAIL areset streak got %0d/%0d exp 0", streak, max_streak); else n_pass++;
    n_tot++; if (hist_valid !== 1'b0 || hist_level !== 4'd0 || hist_ovf !== 1'b0 || hist_data !== 11'd0) $display("FAIL areset hist got %b/%0d/%b/%h exp 0", hist_valid, hist_level, hist_ovf, hist_data); else n_pass++;
    roll_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    n_tot++; if (roll_count !== 16'd0) $display("FAIL areset roll_discard got %0d exp 0", roll_count); else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_illegal();
    test_overflow();
    test_full_pushpop();
    test_random();
    test_saturation();
    test_clear_with_roll();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/roll_tally.md
# roll_tally

Downstream statistics stage for the d20 roller: consumes each resolved roll (`random_num`, `final_num`, `hit`) from the number/resolve stage, keeps saturating tallies and a hit-streak tracker, and buffers the most recent rolls in a small history FIFO. The history is drained by the display/host side through a valid/read handshake. It sits directly after `top`'s result outputs, at the same clock.

## Interface
- `NUM_BITS`, 8: width of signed `final_num` and history value
- `CNT_BITS`, 16: width of every tally counter
- `SUM_BITS`, 16: width of signed running sum of `final_num`
- `HIST_DEPTH`, 8: history FIFO entries, power of two, ≥2

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `clear`  in  1  synchronous clear, same effect as reset
- `roll_valid`  in  1  one-cycle strobe: a new roll result is present
- `random_num`  in  5  natural die value, legal 1..20
- `final_num`  in  NUM_BITS signed  die + modifier
- `hit`  in  1  `final_num` ≥ target
- `roll_count`, `hit_count`, `crit_count`, `fumble_count`, `err_count`  out  CNT_BITS  tallies
- `sum`  out  SUM_BITS signed  running sum of accepted `final_num`
- `streak`, `max_streak`  out  CNT_BITS  current / best consecutive-hit run
- `hist_valid`  out  1  FIFO non-empty
- `hist_data`  out  NUM_BITS+3  oldest entry {crit, fumble, hit, final_num}
- `hist_rd`  in  1  pop oldest entry when `hist_valid`
- `hist_level`  out  $clog2(HIST_DEPTH)+1  occupancy
- `hist_ovf`  out  1  sticky: an entry was overwritten

## Operation
- Roll sampled on `clk` edge with `roll_valid`=1. Legal iff `random_num` in 1..20.
- Illegal roll: only `err_count` increments; nothing else changes, no FIFO push.
- Legal roll: `roll_count`+1; `hit_count`+1 if `hit`; `crit_count`+1 if `random_num`=20; `fumble_count`+1 if `random_num`=1; `sum` += sign-extended `final_num`.
- All counters saturate at all-ones; `sum` saturates at signed max/min, never wraps.
- Streak: legal hit → `streak`+1 (saturating), `max_streak` = max(`max_streak`, new `streak`) in the same update; legal miss → `streak`=0. Illegal roll leaves streak untouched.
- History: each legal roll pushes {crit, fumble, hit, final_num}. Push when full overwrites the oldest entry, level stays HIST_DEPTH, `hist_ovf` set until reset/clear.
- Pop: `hist_rd` with `hist_valid`=1 removes oldest; `hist_rd` when empty is ignored, no underflow.
- Simultaneous push+pop: non-full → level unchanged, pop returns old head; full → pop takes the head, push fills the freed slot, no overflow flagged. Empty + push + pop → pop ignored, level becomes 1.
- `clear` and `roll_valid` in same cycle: clear wins, roll discarded.
- FIFO is show-ahead: `hist_data` is the head whenever `hist_valid`=1; don't-care otherwise.

## Timing
- Reset/clear values: all counters 0, `sum` 0, `streak`/`max_streak` 0, `hist_level` 0, `hist_valid` 0, `hist_ovf` 0, `hist_data` 0.
- Every tally, `sum`, and streak output is registered, updated on the edge that samples `roll_valid`; visible one cycle after the strobe.
- Push into empty FIFO → `hist_valid` high the following cycle.
- Pop takes effect on the sampling edge; the next head is visible the next cycle.
- Back-to-back `roll_valid` every cycle is supported with no lost rolls. There is no backpressure to upstream.
- Reset mid-operation: asynchronous clear of every register, including FIFO pointers. Storage contents need not clear, but `hist_data` reads 0 while empty.

## Structure
- Shared `d20_pkg`: `D20_MIN`=1, `D20_MAX`=20, default `NUM_BITS`, typedef `roll_entry_t` packed struct {crit, fumble, hit, logic signed [NUM_BITS-1:0] value}.
- Sub-module `roll_hist_fifo`: circular buffer with overwrite-on-full, level and sticky overflow. `roll_tally` holds classification, counters, saturation and streak logic.

## Test plan
- Reset then three legal rolls (random 20/final 25/hit, 1/−2/miss, 12/12/hit) → roll 3, hit 2, crit 1, fumble 1, sum 35, streak 1, max_streak 1, level 3.
- `random_num`=0 and 21 strobed → err_count 2, other tallies and FIFO unchanged.
- HIST_DEPTH+2 legal rolls with values 1..10, no pops → level 8, hist_ovf 1; draining yields 3..10 in order, then hist_valid 0.
- Full FIFO with push+pop in the same cycle → level stays 8, hist_ovf stays 0, popped value equals old head.
- `final_num`=127 repeated with SUM_BITS=8 → sum saturates at 127. Counter preloaded near max → holds at all-ones.
- Assert `reset` asynchronously mid-stream, and separately `clear` with `roll_valid` → all outputs 0 immediately or the next cycle respectively; the roll is not counted.
